// File: rtl/rr_grant_requester.sv
// rr_grant_requester: per-source flit FIFOs feeding a round-robin arbiter, forwarding whole granted packets to one output.
module rr_grant_requester #(
  parameter int N_IN       = 2,
  parameter int FLIT_W     = 34,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [N_IN-1:0]        in_valid_i,
  output logic [N_IN-1:0]        in_ready_o,
  input  logic [N_IN*FLIT_W-1:0] in_flit_i,
  input  logic [N_IN-1:0]        in_last_i,
  output logic [N_IN-1:0]        req_o,
  input  logic [N_IN-1:0]        grant_i,
  output logic                   update_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [FLIT_W-1:0]      out_flit_o,
  output logic                   out_last_o,
  output logic                   locked_o,
  output logic                   err_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = N_IN > 1 ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {IDLE, LOCKED, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d, gidx;
  logic            err_q, err_d, onehot;
  logic [FLIT_W:0] mem_q [N_IN][FIFO_DEPTH];
  logic [PW-1:0]   rd_q [N_IN];
  logic [PW-1:0]   wr_q [N_IN];
  logic [CW-1:0]   cnt_q [N_IN];
  logic [N_IN-1:0] full, empty, push, pop;
  logic [FLIT_W:0] head;

  // Full is taken from registered occupancy only, so a popping full FIFO still refuses a push.
  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      full[k]  = cnt_q[k] == CW'(FIFO_DEPTH);
      empty[k] = cnt_q[k] == '0;
      push[k]  = in_valid_i[k] & ~full[k];
      pop[k]   = state_q == LOCKED && sel_q == SW'(k) && !empty[k] && out_ready_i;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_IN; k++) begin
      if (push[k]) mem_q[k][wr_q[k]] <= {in_last_i[k], in_flit_i[k*FLIT_W +: FLIT_W]};
      if (arst) begin
        rd_q[k]  <= '0;
        wr_q[k]  <= '0;
        cnt_q[k] <= '0;
      end else begin
        if (push[k]) wr_q[k] <= wr_q[k] + 1'b1;
        if (pop[k]) rd_q[k] <= rd_q[k] + 1'b1;
        cnt_q[k] <= cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      end
    end
  end

  always_comb begin
    onehot = grant_i != '0 && (grant_i & (grant_i - 1'b1)) == '0;
    gidx = '0;
    for (int k = 0; k < N_IN; k++) if (grant_i[k]) gidx = SW'(k);
    head        = mem_q[sel_q][rd_q[sel_q]];
    state_d     = state_q;
    sel_d       = sel_q;
    err_d       = err_q;
    req_o       = '0;
    update_o    = 1'b0;
    out_valid_o = 1'b0;
    locked_o    = 1'b0;
    case (state_q)
      IDLE: begin
        req_o = ~empty;
        if (grant_i != '0) begin
          if (onehot && (grant_i & ~empty) != '0) begin
            sel_d   = gidx;
            state_d = LOCKED;
          end else err_d = 1'b1;
        end
      end
      LOCKED: begin
        locked_o    = 1'b1;
        out_valid_o = !empty[sel_q];
        if (grant_i != '0) err_d = 1'b1;
        if (out_valid_o && out_ready_i && head[FLIT_W]) state_d = RELEASE;
      end
      RELEASE: begin
        update_o = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o = ~full;
  assign out_flit_o = head[FLIT_W-1:0];
  assign out_last_o = head[FLIT_W];
  assign err_o      = err_q;
endmodule
